// File: rtl/mips_bus_pkg.sv
// Shared types and constants for the two-master Avalon-style CPU memory bus.
package mips_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [BE_W-1:0]   byteenable;
  } avalon_req_t;

  localparam avalon_req_t AVALON_REQ_IDLE = '{
    address:    32'h0000_0000,
    read:       1'b0,
    write:      1'b0,
    writedata:  32'h0000_0000,
    byteenable: 4'h0
  };

  function automatic logic req_active(input avalon_req_t r);
    return r.read | r.write;
  endfunction

endpackage

// File: rtl/mips_bus_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over enable).
module mips_bus_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_d;
  logic [W-1:0] count_q;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = {W{1'b0}};
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Count register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= {W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mips_bus_arbiter.sv
// Round-robin two-master arbiter with transaction lock, stall watchdog and
// per-master stall statistics for a single Avalon-style memory slave.
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      m0_address,
  input  logic             m0_read,
  input  logic             m0_write,
  input  logic [31:0]      m0_writedata,
  input  logic [3:0]       m0_byteenable,
  output logic             m0_waitrequest,
  output logic [31:0]      m0_readdata,
  input  logic [31:0]      m1_address,
  input  logic             m1_read,
  input  logic             m1_write,
  input  logic [31:0]      m1_writedata,
  input  logic [3:0]       m1_byteenable,
  output logic             m1_waitrequest,
  output logic [31:0]      m1_readdata,
  output logic [31:0]      s_address,
  output logic             s_read,
  output logic             s_write,
  output logic [31:0]      s_writedata,
  output logic [3:0]       s_byteenable,
  input  logic             s_waitrequest,
  input  logic [31:0]      s_readdata,
  output logic [1:0]       grant,
  output logic             timeout,
  output logic [CNT_W-1:0] m0_stalls,
  output logic [CNT_W-1:0] m1_stalls
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  arb_state_e  state_d, state_q;
  logic        last_d, last_q;
  logic        timeout_d, timeout_q;
  avalon_req_t m0_req_s, m1_req_s, s_req_s;
  logic        req0_s, req1_s;
  logic        m0_wait_s, m1_wait_s;
  logic        wd_inc_s;
  logic [WD_W-1:0] wd_cnt_s;

  assign m0_req_s = '{address: m0_address, read: m0_read, write: m0_write,
                      writedata: m0_writedata, byteenable: m0_byteenable};
  assign m1_req_s = '{address: m1_address, read: m1_read, write: m1_write,
                      writedata: m1_writedata, byteenable: m1_byteenable};
  assign req0_s   = req_active(m0_req_s);
  assign req1_s   = req_active(m1_req_s);

  // Next-state arbitration; last_q names the previous winner so ties go to the other master
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req0_s && req1_s) begin
          state_d = last_q ? GNT0 : GNT1;
        end else if (req0_s) begin
          state_d = GNT0;
        end else if (req1_s) begin
          state_d = GNT1;
        end else begin
          state_d = IDLE;
        end
      end
      GNT0: begin
        if (!req0_s) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b0;
          state_d = req1_s ? GNT1 : GNT0;
        end else begin
          state_d = GNT0;
        end
      end
      GNT1: begin
        if (!req1_s) begin
          state_d = IDLE;
        end else if (!s_waitrequest) begin
          last_d  = 1'b1;
          state_d = req0_s ? GNT0 : GNT1;
        end else begin
          state_d = GNT1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slave-side mux and master stalls follow the registered owner
  always_comb begin
    s_req_s   = AVALON_REQ_IDLE;
    m0_wait_s = 1'b1;
    m1_wait_s = 1'b1;
    case (state_q)
      GNT0: begin
        s_req_s   = m0_req_s;
        m0_wait_s = s_waitrequest;
      end
      GNT1: begin
        s_req_s   = m1_req_s;
        m1_wait_s = s_waitrequest;
      end
      default: begin
        s_req_s = AVALON_REQ_IDLE;
      end
    endcase
  end

  assign wd_inc_s  = s_waitrequest &
                     (((state_q == GNT0) & req0_s) | ((state_q == GNT1) & req1_s));
  assign timeout_d = timeout_q |
                     (wd_inc_s & (wd_cnt_s >= WD_W'(TIMEOUT_CYCLES - 1)));

  // Arbiter state, round-robin pointer and sticky watchdog flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      timeout_q <= timeout_d;
    end
  end

  mips_bus_sat_counter #(.W(WD_W)) u_watchdog (
    .clk(clk), .reset(reset), .en(wd_inc_s), .clr(~wd_inc_s), .count(wd_cnt_s)
  );

  mips_bus_sat_counter #(.W(CNT_W)) u_m0_stalls (
    .clk(clk), .reset(reset), .en(req0_s & m0_wait_s), .clr(1'b0), .count(m0_stalls)
  );

  mips_bus_sat_counter #(.W(CNT_W)) u_m1_stalls (
    .clk(clk), .reset(reset), .en(req1_s & m1_wait_s), .clr(1'b0), .count(m1_stalls)
  );

  assign s_address      = s_req_s.address;
  assign s_read         = s_req_s.read;
  assign s_write        = s_req_s.write;
  assign s_writedata    = s_req_s.writedata;
  assign s_byteenable   = s_req_s.byteenable;
  assign m0_waitrequest = m0_wait_s;
  assign m1_waitrequest = m1_wait_s;
  assign m0_readdata    = s_readdata;
  assign m1_readdata    = s_readdata;
  assign grant          = {state_q == GNT1, state_q == GNT0};
  assign timeout        = timeout_q;

endmodule

// File: tb/tb_mips_bus_arbiter.sv
// Directed bench for mips_bus_arbiter with a short watchdog (TIMEOUT_CYCLES=8).
module tb_mips_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [3:0]  m0_byteenable, m1_byteenable;
  logic        m0_waitrequest, m1_waitrequest;
  logic [31:0] m0_readdata, m1_readdata;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest;
  logic [3:0]  s_byteenable;
  logic [1:0]  grant;
  logic        timeout;
  logic [31:0] m0_stalls, m1_stalls;

  int n_chk  = 0;
  int n_fail = 0;

  mips_bus_arbiter #(.TIMEOUT_CYCLES(8), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .s_address(s_address), .s_read(s_read), .s_write(s_write),
    .s_writedata(s_writedata), .s_byteenable(s_byteenable),
    .s_waitrequest(s_waitrequest), .s_readdata(s_readdata),
    .grant(grant), .timeout(timeout),
    .m0_stalls(m0_stalls), .m1_stalls(m1_stalls)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [1:0] alt_exp [4];
    alt_exp[0] = 2'b01; alt_exp[1] = 2'b10; alt_exp[2] = 2'b01; alt_exp[3] = 2'b10;

    reset = 1'b0;
    m0_address = 32'h0; m0_read = 1'b0; m0_write = 1'b0; m0_writedata = 32'h0; m0_byteenable = 4'h0;
    m1_address = 32'h0; m1_read = 1'b0; m1_write = 1'b0; m1_writedata = 32'h0; m1_byteenable = 4'h0;
    s_waitrequest = 1'b0; s_readdata = 32'h0;
    #2;
    chk("rst_grant", grant, 2'b00);
    chk("rst_m0_wait", m0_waitrequest, 1'b1);
    chk("rst_m1_wait", m1_waitrequest, 1'b1);
    chk("rst_s_read", s_read, 1'b0);
    chk("rst_s_addr", s_address, 32'h0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_m0_stalls", m0_stalls, 32'd0);
    step(); step();
    reset = 1'b1;

    // single m0 read, slave ready at once
    m0_read = 1'b1; m0_address = 32'hBFC0_0000; m0_byteenable = 4'hF; s_readdata = 32'hDEAD_BEEF;
    #1;
    chk("t1_idle_grant", grant, 2'b00);
    chk("t1_idle_wait", m0_waitrequest, 1'b1);
    chk("t1_idle_sread", s_read, 1'b0);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_sread", s_read, 1'b1);
    chk("t1_saddr", s_address, 32'hBFC0_0000);
    chk("t1_m0_wait", m0_waitrequest, 1'b0);
    chk("t1_m1_wait", m1_waitrequest, 1'b1);
    chk("t1_rdata", m0_readdata, 32'hDEAD_BEEF);
    chk("t1_m1_rdata", m1_readdata, 32'hDEAD_BEEF);
    step();
    m0_read = 1'b0;
    #1;
    chk("t1_sread_done", s_read, 1'b0);
    step();
    chk("t1_back_idle", grant, 2'b00);
    chk("t1_m0_stalls", m0_stalls, 32'd1);

    // reset restores round-robin pointer so m0 wins the tie
    reset = 1'b0;
    #1;
    chk("t2_rst_stalls", m0_stalls, 32'd0);
    step();
    reset = 1'b1;
    m0_write = 1'b1; m0_address = 32'h100; m0_writedata = 32'h1111_1111; m0_byteenable = 4'hF;
    m1_write = 1'b1; m1_address = 32'h200; m1_writedata = 32'h2222_2222; m1_byteenable = 4'h3;
    step();
    chk("t2_grant0", grant, 2'b01);
    chk("t2_swrite", s_write, 1'b1);
    chk("t2_sdata0", s_writedata, 32'h1111_1111);
    chk("t2_m1_wait", m1_waitrequest, 1'b1);
    step();
    m0_write = 1'b0;
    #1;
    chk("t2_grant1", grant, 2'b10);
    chk("t2_saddr1", s_address, 32'h200);
    chk("t2_sbe1", s_byteenable, 4'h3);
    chk("t2_m1_wait1", m1_waitrequest, 1'b0);
    chk("t2_m0_wait1", m0_waitrequest, 1'b1);
    chk("t2_m1_stalls", m1_stalls, 32'd2);
    chk("t2_m0_stalls", m0_stalls, 32'd1);
    step();
    m1_write = 1'b0;
    step();
    chk("t2_idle", grant, 2'b00);

    // continuous requests from both: grants alternate
    m0_read = 1'b1; m0_address = 32'h400;
    m1_read = 1'b1; m1_address = 32'h500;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t3_alt_grant", grant, alt_exp[i]);
    end
    m0_read = 1'b0; m1_read = 1'b0;
    step();
    chk("t3_idle", grant, 2'b00);
    chk("t3_m0_stalls", m0_stalls, 32'd3);
    chk("t3_m1_stalls", m1_stalls, 32'd5);

    // m1 write stalled by slave; watchdog fires after 8 stalled cycles
    m1_write = 1'b1; m1_address = 32'h300; m1_writedata = 32'hCAFE_F00D; m1_byteenable = 4'b0101;
    s_waitrequest = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      chk("t4_grant", grant, 2'b10);
      chk("t4_m1_wait", m1_waitrequest, 1'b1);
      chk("t4_m0_wait", m0_waitrequest, 1'b1);
      chk("t4_sdata", s_writedata, 32'hCAFE_F00D);
      chk("t4_sbe", s_byteenable, 4'b0101);
      chk("t4_timeout", timeout, (k >= 9) ? 1'b1 : 1'b0);
    end
    step();
    s_waitrequest = 1'b0;
    #1;
    chk("t4_m1_release", m1_waitrequest, 1'b0);
    chk("t4_m1_stalls", m1_stalls, 32'd16);
    chk("t4_grant_kept", grant, 2'b10);
    step();
    m1_write = 1'b0;
    step(); step();
    chk("t5_idle", grant, 2'b00);
    chk("t5_sticky", timeout, 1'b1);
    reset = 1'b0;
    #1;
    chk("t5_rst_clear", timeout, 1'b0);
    step();
    reset = 1'b1;

    // reset asserted mid-transaction with slave stalled
    m0_read = 1'b1; m0_address = 32'h600; s_waitrequest = 1'b1;
    step(); step();
    chk("t6_pre_grant", grant, 2'b01);
    chk("t6_pre_sread", s_read, 1'b1);
    reset = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_sread", s_read, 1'b0);
    chk("t6_rst_m0_wait", m0_waitrequest, 1'b1);
    chk("t6_rst_m1_wait", m1_waitrequest, 1'b1);
    chk("t6_rst_stalls", m0_stalls, 32'd0);
    step();
    reset = 1'b1;
    #1;
    chk("t6_rearb_idle", grant, 2'b00);
    step();
    chk("t6_rearb_grant", grant, 2'b01);
    chk("t6_rearb_stalls", m0_stalls, 32'd1);
    s_waitrequest = 1'b0;
    step();
    m0_read = 1'b0;
    step();
    chk("t6_final_idle", grant, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
